// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state and op encodings,
// plus the width and saturating-increment helper used by the perf counters.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int PERF_W = 32;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first requesting index at or
// after rr_ptr, wrapping from NUM_CORES-1 back to 0.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     grant,
    output logic                 any_req
);

    always_comb begin
        int             idx;
        logic [IDX_W-1:0] sel;
        idx     = 0;
        sel     = '0;
        grant   = '0;
        any_req = |req;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            sel = idx[IDX_W-1:0];
            if (req[sel]) begin
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory among NUM_CORES cores.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_memread,
    input  logic [NUM_CORES-1:0]        core_memwr,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_done,
    output logic [NUM_CORES-1:0]        core_stall,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_read,
    output logic                        mem_wr,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]           perf_xfers,
    output logic [PERF_W-1:0]           perf_stall_cycles
`endif
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     next_ptr;
    logic                 any_req;
    logic                 op;
    logic [CNT_W-1:0]     lat_cnt;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] grant_onehot;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    assign req          = core_memread | core_memwr;
    assign core_stall   = req & ~core_done;
    assign grant_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << grant;
    assign next_ptr     = (grant == IDX_W'(NUM_CORES - 1)) ? '0 : grant + IDX_W'(1);

    rr_picker #(
        .NUM_CORES(NUM_CORES),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .any_req(any_req)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The memory port registers double as the request latch: they are loaded on
    // the IDLE->ISSUE edge so the strobe and address appear during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lat_cnt    <= '0;
            grant      <= '0;
            op         <= OP_RD;
            core_done  <= '0;
            core_rdata <= '0;
            mem_read   <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            core_done <= '0;
            mem_read  <= 1'b0;
            mem_wr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        op        <= core_memwr[pick] ? OP_WR : OP_RD;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_wr    <= core_memwr[pick];
                        mem_read  <= ~core_memwr[pick];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op == OP_WR) begin
                        core_done <= grant_onehot;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= CNT_W'(MEM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        core_rdata <= mem_rdata;
                        core_done  <= grant_onehot;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_xfers        <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == DONE) begin
                perf_xfers <= sat_inc(perf_xfers);
            end
            if (|core_stall) begin
                perf_stall_cycles <= sat_inc(perf_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized core traffic, all
// checked against a transaction-level schedule model and a reference memory.
module tb_dmem_arbiter;

    localparam int NUM_CORES = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_LAT   = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_CORES-1:0]        core_memread = '0;
    logic [NUM_CORES-1:0]        core_memwr = '0;
    logic [NUM_CORES*ADDR_W-1:0] core_addr = '0;
    logic [NUM_CORES*DATA_W-1:0] core_wdata = '0;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES-1:0]        core_stall;
    logic [DATA_W-1:0]           core_rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_read;
    logic                        mem_wr;
    logic [DATA_W-1:0]           mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]                 perf_xfers;
    logic [31:0]                 perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_CORES(NUM_CORES),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_memread     (core_memread),
        .core_memwr       (core_memwr),
        .core_addr        (core_addr),
        .core_wdata       (core_wdata),
        .core_done        (core_done),
        .core_stall       (core_stall),
        .core_rdata       (core_rdata),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_read         (mem_read),
        .mem_wr           (mem_wr),
        .mem_rdata        (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_xfers       (perf_xfers),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    function automatic logic [DATA_W-1:0] mem_init(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a ^ 8'h5A, ~a};
    endfunction

    // Data memory: writes on the strobe edge, read data valid MEM_LAT cycles after mem_read.
    logic [DATA_W-1:0] mem_arr [256];
    bit                mem_set [256];
    logic [7:0]        rd_addr_pipe [MEM_LAT];
    logic              rd_vld_pipe [MEM_LAT];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            mem_set[mem_addr[7:0]] <= 1'b1;
        end
        rd_addr_pipe[0] <= mem_addr[7:0];
        rd_vld_pipe[0]  <= mem_read;
        for (int k = 1; k < MEM_LAT; k++) begin
            rd_addr_pipe[k] <= rd_addr_pipe[k-1];
            rd_vld_pipe[k]  <= rd_vld_pipe[k-1];
        end
    end

    always_comb begin
        mem_rdata = 16'hDEAD;
        if (rd_vld_pipe[MEM_LAT-1] === 1'b1) begin
            mem_rdata = mem_set[rd_addr_pipe[MEM_LAT-1]] ? mem_arr[rd_addr_pipe[MEM_LAT-1]]
                                                         : mem_init(rd_addr_pipe[MEM_LAT-1]);
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: one transaction at a time, scheduled by cycle number.
    bit                   t_act = 1'b0;
    int                   t_core = 0;
    bit                   t_wr = 1'b0;
    logic [ADDR_W-1:0]    t_addr = '0;
    logic [DATA_W-1:0]    t_wdata = '0;
    int                   t_issue = 0;
    int                   t_done = 0;
    int                   ptr = 0;
    int                   free_cyc = 0;
    logic [DATA_W-1:0]    ref_mem [256];
    logic [DATA_W-1:0]    exp_rdata = '0;
    logic [ADDR_W-1:0]    exp_maddr = '0;
    logic [DATA_W-1:0]    exp_mwdata = '0;
    logic [NUM_CORES-1:0] cur_done = '0;
    longint               perf_x = 0;
    longint               perf_s = 0;
    int                   policy = 0;
    int                   last_core = 0;

    // Observations of the DUT's own done pulses.
    int                   dut_done_cnt = 0;
    int                   dut_last_cyc = 0;
    logic [NUM_CORES-1:0] dut_last_vec = '0;
    int                   grant_log[$];
    int                   done_cyc_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        core_memread[c]                = rd;
        core_memwr[c]                  = wr;
        core_addr[c*ADDR_W +: ADDR_W]  = a;
        core_wdata[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic rand_req(input int c);
        int k;
        k = $urandom_range(0, 9);
        set_req(c, (k <= 4) || (k == 9), k >= 5, 16'($urandom) & 16'hF00F, 16'($urandom));
    endtask

    // Close the current cycle: the inputs are final, so check stall and let the model arbitrate.
    task automatic settle();
        logic [NUM_CORES-1:0] req;
        int                   win;
        int                   c;
        #1;
        req = core_memread | core_memwr;
        chk("core_stall", core_stall, req & ~cur_done);
        if (!rst) begin
            if (cur_done != '0) perf_x++;
            if ((req & ~cur_done) != '0) perf_s++;
            if (!t_act && cyc == free_cyc) begin
                win = -1;
                for (int k = 0; k < NUM_CORES; k++) begin
                    c = (ptr + k) % NUM_CORES;
                    if (win < 0 && req[c]) win = c;
                end
                if (win >= 0) begin
                    t_act   = 1'b1;
                    t_core  = win;
                    t_wr    = core_memwr[win];
                    t_addr  = core_addr[win*ADDR_W +: ADDR_W];
                    t_wdata = core_wdata[win*DATA_W +: DATA_W];
                    t_issue = cyc + 1;
                    t_done  = cyc + 2 + (t_wr ? 0 : MEM_LAT);
                end else begin
                    free_cyc = cyc + 1;
                end
            end
        end
    endtask

    task automatic drive_policy();
        if (cur_done != '0) begin
            if (policy != 1) set_req(last_core, 1'b0, 1'b0, '0, '0);
            if (policy == 2 && $urandom_range(0, 1) == 1) rand_req(last_core);
        end
        if (policy == 2) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!(core_memread[i] | core_memwr[i]) && $urandom_range(0, 3) == 0) rand_req(i);
            end
        end
    endtask

    task automatic step();
        bit rst_at_edge;
        bit issue;
        settle();
        rst_at_edge = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_at_edge) begin
            t_act      = 1'b0;
            ptr        = 0;
            free_cyc   = cyc;
            exp_rdata  = '0;
            exp_maddr  = '0;
            exp_mwdata = '0;
            perf_x     = 0;
            perf_s     = 0;
        end
        cur_done = '0;
        if (t_act && cyc == t_done) begin
            cur_done[t_core] = 1'b1;
            if (!t_wr) exp_rdata = ref_mem[t_addr[7:0]];
        end
        issue = t_act && (cyc == t_issue);
        if (issue) begin
            exp_maddr  = t_addr;
            exp_mwdata = t_wdata;
            if (t_wr) ref_mem[t_addr[7:0]] = t_wdata;
        end
        chk("core_done", core_done, cur_done);
        chk("core_rdata", core_rdata, exp_rdata);
        chk("mem_read", mem_read, issue && !t_wr);
        chk("mem_wr", mem_wr, issue && t_wr);
        chk("mem_addr", mem_addr, exp_maddr);
        chk("mem_wdata", mem_wdata, exp_mwdata);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_xfers", perf_xfers, 32'(perf_x));
        chk("perf_stall", perf_stall_cycles, 32'(perf_s));
`endif
        if (core_done != '0) begin
            dut_done_cnt++;
            dut_last_cyc = cyc;
            dut_last_vec = core_done;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_done[i]) grant_log.push_back(i);
            end
            done_cyc_log.push_back(cyc);
        end
        if (cur_done != '0) begin
            last_core = t_core;
            ptr       = (t_core + 1) % NUM_CORES;
            free_cyc  = cyc + 1;
            t_act     = 1'b0;
        end
        drive_policy();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (!t_act && (core_memread | core_memwr) == '0) return;
        end
        chk("idle_timeout", {t_act, core_memread | core_memwr}, 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (core_done != '0) return;
        end
        chk("done_timeout", |core_done, 1);
    endtask

    initial begin
        int start;
        int cnt0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));

        rst = 1'b1;
        repeat (3) step();
        chk("rst_rdata", core_rdata, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;

        // Single read from core1.
        policy = 0;
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        start = cyc;
        wait_idle(50);
        chk("rd_latency", dut_last_cyc - start, 2 + MEM_LAT);
        chk("rd_core", dut_last_vec, 4'b0010);
        chk("rd_data", core_rdata, 16'hBEEF);

        // Single write from core2, then read it back through core0.
        step();
        set_req(2, 1'b0, 1'b1, 16'h0020, 16'h1234);
        start = cyc;
        wait_idle(50);
        chk("wr_latency", dut_last_cyc - start, 2);
        chk("wr_core", dut_last_vec, 4'b0100);
        step();
        set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        wait_idle(50);
        chk("raw_data", core_rdata, 16'h1234);

        // Read and write together from core3: the write wins.
        step();
        set_req(3, 1'b1, 1'b1, 16'h0005, 16'h00AA);
        cnt0 = dut_done_cnt;
        wait_idle(50);
        chk("both_done_count", dut_done_cnt - cnt0, 1);
        chk("both_rdata_kept", core_rdata, 16'h1234);
        step();
        set_req(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        wait_idle(50);
        chk("both_written", core_rdata, 16'h00AA);

        // Reset while core0's read is waiting on memory; rr_ptr is 1 beforehand.
        step();
        set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rstmid_done", core_done, 4'b0000);
        chk("rstmid_read", mem_read, 1'b0);
        set_req(3, 1'b0, 1'b1, 16'h0030, 16'h3333);
        rst = 1'b0;
        grant_log.delete();
        wait_idle(60);
        chk("rstmid_grants", grant_log.size(), 2);
        if (grant_log.size() >= 1) chk("rstmid_first", grant_log[0], 0);
        chk("rstmid_rdata", core_rdata, 16'hBEEF);

        // All cores write continuously from reset.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        policy = 1;
        for (int i = 0; i < NUM_CORES; i++) set_req(i, 1'b0, 1'b1, 16'(16'h0080 + i), 16'(16'hA000 + i));
        grant_log.delete();
        done_cyc_log.delete();
        for (int i = 0; i < 40 && grant_log.size() < 5; i++) step();
        chk("rr_count", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 2);
            chk("rr_g3", grant_log[3], 3);
            chk("rr_g4", grant_log[4], 0);
            for (int i = 1; i < 5; i++) chk("rr_spacing", done_cyc_log[i] - done_cyc_log[i-1], 3);
        end
        policy = 0;
        wait_idle(100);

`ifdef DMEM_ARB_PERF_EN
        // Three back-to-back writes from one core after a fresh reset.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1'b0, 1'b1, 16'(16'h0040 + i), 16'(16'h0100 + i));
            wait_done(20);
        end
        step();
        step();
        chk("perf3_xfers", perf_xfers, 3);
        chk("perf3_stall", perf_stall_cycles, 6);
`endif

        // Randomized traffic from all cores.
        policy = 2;
        repeat (1500) step();
        policy = 0;
        wait_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
